// File: rtl/fp32_pkg.sv
// Shared types and constants for the FP32 iterative divider.
package fp32_pkg;
    localparam int          FP_BIAS    = 127;
    localparam int          FP_EXP_MAX = 255;
    localparam logic [31:0] FP_INF     = 32'h7F800000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_ITER  = 3'd2,
        ST_ROUND = 3'd3,
        ST_DONE  = 3'd4
    } div_state_t;

    typedef enum logic [1:0] {
        CLS_ZERO   = 2'd0,
        CLS_NORMAL = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } fp_class_t;

    typedef struct packed {
        logic invalid;
        logic div_by_zero;
        logic overflow;
        logic underflow;
    } fp_flags_t;
endpackage

// File: rtl/fp32_div_iter_if.sv
// Request/response handshake bundle for the FP32 divider.
interface fp32_div_iter_if;
    import fp32_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    fp_flags_t   flags;

    modport master (output in_valid, a, b, out_ready,
                    input  in_ready, out_valid, result, flags);
    modport slave  (input  in_valid, a, b, out_ready,
                    output in_ready, out_valid, result, flags);
endinterface

// File: rtl/fp32_classify.sv
// Splits an FP32 word into fields and classifies it; denormals read as zero.
module fp32_classify
    import fp32_pkg::*;
(
    input  logic [31:0] x,
    output logic        sign,
    output logic [7:0]  exp,
    output logic [23:0] mant,
    output fp_class_t   cls
);
    // Field extraction with DAZ: a zero exponent drops the fraction entirely.
    always_comb begin
        sign = x[31];
        exp  = x[30:23];
        mant = {1'b1, x[22:0]};
        cls  = CLS_NORMAL;
        if (x[30:23] == 8'd0) begin
            cls  = CLS_ZERO;
            mant = 24'd0;
        end else if (x[30:23] == 8'hFF) begin
            cls = (x[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
        end
    end
endmodule

// File: rtl/fp32_div_iter.sv
// Iterative FP32 divider: restoring radix-2, one quotient bit per cycle, RNE, DAZ/FTZ.
module fp32_div_iter
    import fp32_pkg::*;
#(
    parameter logic [31:0] QNAN          = 32'h7FC00000,
    parameter bit          EARLY_SPECIAL = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    fp32_div_iter_if.slave io
);
    div_state_t        state_q, state_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic              sign_q, sign_d;
    logic signed [9:0] exp_q, exp_d;
    logic [24:0]       rem_q, rem_d;
    logic [23:0]       div_q, div_d;
    logic [26:0]       q_q, q_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              spec_q, spec_d;
    logic [31:0]       spec_res_q, spec_res_d;
    fp_flags_t         spec_flags_q, spec_flags_d;
    logic [31:0]       result_q, result_d;
    fp_flags_t         flags_q, flags_d;

    logic              sa, sb;
    logic [7:0]        ea, eb;
    logic [23:0]       ma, mb;
    fp_class_t         ca, cb;

    fp32_classify u_cls_a (.x(a_q), .sign(sa), .exp(ea), .mant(ma), .cls(ca));
    fp32_classify u_cls_b (.x(b_q), .sign(sb), .exp(eb), .mant(mb), .cls(cb));

    assign io.in_ready  = (state_q == ST_IDLE);
    assign io.out_valid = (state_q == ST_DONE);
    assign io.result    = result_q;
    assign io.flags     = flags_q;

    logic [25:0]       qn;
    logic signed [9:0] e_r;
    logic              guard, sticky;
    logic [23:0]       frac_inc;
    logic [22:0]       frac;
    logic [31:0]       rnd_res;
    fp_flags_t         rnd_flags;

    // Normalise the raw quotient, round to nearest-even, then range-check.
    // qn holds only the bits below the leading one, which is always set here.
    always_comb begin
        qn  = q_q[25:0];
        e_r = exp_q;
        if (!q_q[26]) begin
            qn  = {q_q[24:0], 1'b0};
            e_r = exp_q - 10'sd1;
        end
        guard    = qn[2];
        sticky   = (|qn[1:0]) | (|rem_q);
        frac_inc = {1'b0, qn[25:3]} + {23'd0, guard & (sticky | qn[3])};
        frac     = frac_inc[22:0];
        if (frac_inc[23]) begin
            frac = 23'd0;
            e_r  = e_r + 10'sd1;
        end
        rnd_flags = '0;
        if (e_r >= 10'(FP_EXP_MAX)) begin
            rnd_res            = {sign_q, FP_INF[30:0]};
            rnd_flags.overflow = 1'b1;
        end else if (e_r <= 10'sd0) begin
            rnd_res             = {sign_q, 31'd0};
            rnd_flags.underflow = 1'b1;
        end else begin
            rnd_res = {sign_q, e_r[7:0], frac};
        end
    end

    // Next-state and datapath for the IDLE/PREP/ITER/ROUND/DONE sequence.
    // Specials skip straight to ROUND when early, else they ride the
    // iteration count so the latency matches a normal divide.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        sign_d       = sign_q;
        exp_d        = exp_q;
        rem_d        = rem_q;
        div_d        = div_q;
        q_d          = q_q;
        cnt_d        = cnt_q;
        spec_d       = spec_q;
        spec_res_d   = spec_res_q;
        spec_flags_d = spec_flags_q;
        result_d     = result_q;
        flags_d      = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (io.in_valid) begin
                    a_d     = io.a;
                    b_d     = io.b;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                sign_d       = sa ^ sb;
                exp_d        = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'(FP_BIAS);
                rem_d        = {1'b0, ma};
                div_d        = mb;
                q_d          = '0;
                cnt_d        = '0;
                spec_d       = 1'b1;
                spec_flags_d = '0;
                if (ca == CLS_NAN || cb == CLS_NAN) begin
                    spec_res_d           = QNAN;
                    spec_flags_d.invalid = 1'b1;
                end else if ((ca == CLS_ZERO && cb == CLS_ZERO) ||
                             (ca == CLS_INF && cb == CLS_INF)) begin
                    spec_res_d           = QNAN;
                    spec_flags_d.invalid = 1'b1;
                end else if (cb == CLS_ZERO) begin
                    spec_res_d               = {sa ^ sb, FP_INF[30:0]};
                    spec_flags_d.div_by_zero = 1'b1;
                end else if (ca == CLS_INF) begin
                    spec_res_d = {sa ^ sb, FP_INF[30:0]};
                end else if (cb == CLS_INF || ca == CLS_ZERO) begin
                    spec_res_d = {sa ^ sb, 31'd0};
                end else begin
                    spec_d     = 1'b0;
                    spec_res_d = '0;
                end
                state_d = (spec_d && EARLY_SPECIAL) ? ST_ROUND : ST_ITER;
            end
            ST_ITER: begin
                if (rem_q >= {1'b0, div_q}) begin
                    rem_d = (rem_q - {1'b0, div_q}) << 1;
                    q_d   = {q_q[25:0], 1'b1};
                end else begin
                    rem_d = rem_q << 1;
                    q_d   = {q_q[25:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd26) state_d = ST_ROUND;
            end
            ST_ROUND: begin
                result_d = spec_q ? spec_res_q   : rnd_res;
                flags_d  = spec_q ? spec_flags_q : rnd_flags;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                if (io.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous reset; reset abandons any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            sign_q       <= 1'b0;
            exp_q        <= '0;
            rem_q        <= '0;
            div_q        <= '0;
            q_q          <= '0;
            cnt_q        <= '0;
            spec_q       <= 1'b0;
            spec_res_q   <= '0;
            spec_flags_q <= '0;
            result_q     <= '0;
            flags_q      <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            sign_q       <= sign_d;
            exp_q        <= exp_d;
            rem_q        <= rem_d;
            div_q        <= div_d;
            q_q          <= q_d;
            cnt_q        <= cnt_d;
            spec_q       <= spec_d;
            spec_res_q   <= spec_res_d;
            spec_flags_q <= spec_flags_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
        end
    end
endmodule

// File: tb/tb_fp32_div_iter.sv
// Self-checking bench: early-special and padded-special dividers run side by side
// against a real-arithmetic reference model.
module tb_fp32_div_iter;
    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fp32_div_iter_if io1 ();
    fp32_div_iter_if io0 ();

    fp32_div_iter #(.QNAN(32'h7FC00000), .EARLY_SPECIAL(1'b1)) dut1 (.clk(clk), .rst(rst), .io(io1));
    fp32_div_iter #(.QNAN(32'h7FC00000), .EARLY_SPECIAL(1'b0)) dut0 (.clk(clk), .rst(rst), .io(io0));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // 0 zero (incl. denormal), 1 normal, 2 inf, 3 nan
    function automatic int fcls(input logic [31:0] x);
        if (x[30:23] == 8'd0) return 0;
        if (x[30:23] != 8'hFF) return 1;
        return (x[22:0] == 23'd0) ? 2 : 3;
    endfunction

    // Reference: {flags, result}; normal path divides exactly-representable doubles
    // and rounds the double quotient to 24 bits (no double-rounding hazard for division).
    function automatic logic [35:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        int          ka, kb, e;
        logic        s;
        real         da, db, dq;
        logic [63:0] qb;
        logic [24:0] m;
        ka = fcls(a);
        kb = fcls(b);
        s  = a[31] ^ b[31];
        if (ka == 3 || kb == 3) return {4'b1000, 32'h7FC00000};
        if ((ka == 0 && kb == 0) || (ka == 2 && kb == 2)) return {4'b1000, 32'h7FC00000};
        if (kb == 0) return {4'b0100, s, 31'h7F800000};
        if (ka == 2) return {4'b0000, s, 31'h7F800000};
        if (kb == 2 || ka == 0) return {4'b0000, s, 31'd0};
        da = $bitstoreal({1'b0, 11'(a[30:23]) + 11'd896, a[22:0], 29'd0});
        db = $bitstoreal({1'b0, 11'(b[30:23]) + 11'd896, b[22:0], 29'd0});
        dq = da / db;
        qb = $realtobits(dq);
        e  = int'(qb[62:52]) - 1023 + 127;
        m  = {2'b01, qb[51:29]};
        if (qb[28] && ((|qb[27:0]) || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = 25'h0800000;
            e = e + 1;
        end
        if (e >= 255) return {4'b0010, s, 31'h7F800000};
        if (e <= 0)   return {4'b0001, s, 31'd0};
        return {4'b0000, s, 8'(e), m[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        int          k;
        logic [7:0]  e;
        logic [31:0] f;
        k = $urandom_range(0, 15);
        f = $urandom;
        if (k == 0)      e = 8'd0;
        else if (k == 1) e = 8'hFF;
        else if (k <= 4) e = 8'($urandom_range(1, 254));
        else             e = 8'($urandom_range(100, 154));
        if (k <= 1 && $urandom_range(0, 1) == 1) f = 32'd0;
        return {f[31], e, f[22:0]};
    endfunction

    // Issue one operation to both dividers and check result, flags and latency.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eres, input logic [3:0] eflg, input bit sp);
        bit          g1, g0;
        int          l1, l0;
        logic [31:0] r1, r0;
        logic [3:0]  f1, f0;
        g1 = 0; g0 = 0; l1 = 0; l0 = 0; r1 = '0; r0 = '0; f1 = '0; f0 = '0;
        io1.a = a; io1.b = b; io1.in_valid = 1'b1;
        io0.a = a; io0.b = b; io0.in_valid = 1'b1;
        @(posedge clk); #1;
        io1.in_valid = 1'b0;
        io0.in_valid = 1'b0;
        for (int c = 1; c <= 60 && !(g1 && g0); c++) begin
            @(posedge clk); #1;
            if (io1.out_valid && !g1) begin g1 = 1; l1 = c; r1 = io1.result; f1 = io1.flags; end
            if (io0.out_valid && !g0) begin g0 = 1; l0 = c; r0 = io0.result; f0 = io0.flags; end
        end
        chk("done_early", {31'd0, g1}, 32'd1);
        chk("done_pad",   {31'd0, g0}, 32'd1);
        chk("res_early",  r1, eres);
        chk("flg_early",  {28'd0, f1}, {28'd0, eflg});
        chk("lat_early",  l1, sp ? 32'd2 : 32'd29);
        chk("res_pad",    r0, eres);
        chk("flg_pad",    {28'd0, f0}, {28'd0, eflg});
        chk("lat_pad",    l0, 32'd29);
        @(posedge clk); #1;
        chk("idle_after", {30'd0, io1.in_ready, io0.in_ready}, 32'd3);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [35:0] e;
        bit          seen;
        rst = 1'b1;
        io1.in_valid = 1'b0; io1.out_ready = 1'b1; io1.a = '0; io1.b = '0;
        io0.in_valid = 1'b0; io0.out_ready = 1'b1; io0.a = '0; io0.b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  {30'd0, io1.in_ready, io0.in_ready}, 32'd3);
        chk("rst_out_valid", {30'd0, io1.out_valid, io0.out_valid}, 32'd0);
        chk("rst_result",    io1.result | io0.result, 32'd0);
        chk("rst_flags",     {24'd0, io1.flags, io0.flags}, 32'd0);
        rst = 1'b0;

        // directed cases with hand-derived expectations
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 0);
        run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 0);
        run_op(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1);
        run_op(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1);
        run_op(32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b0010, 0);
        run_op(32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 0);
        run_op(32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 0);

        // backpressure: result held while the consumer stalls
        io1.out_ready = 1'b0;
        io1.a = 32'h40C00000; io1.b = 32'h40000000; io1.in_valid = 1'b1;
        @(posedge clk); #1;
        io1.in_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(posedge clk); #1;
            seen = io1.out_valid;
        end
        chk("bp_valid", {31'd0, seen}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("bp_hold_res", io1.result, 32'h40400000);
            chk("bp_hold_rdy", {30'd0, io1.in_ready, io1.out_valid}, 32'd1);
        end
        io1.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release", {30'd0, io1.in_ready, io1.out_valid}, 32'd2);

        // reset in the middle of iteration abandons the operation
        io1.a = 32'h3F800000; io1.b = 32'h40400000; io1.in_valid = 1'b1;
        io0.a = 32'h3F800000; io0.b = 32'h40400000; io0.in_valid = 1'b1;
        @(posedge clk); #1;
        io1.in_valid = 1'b0; io0.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_rdy", {30'd0, io1.in_ready, io0.in_ready}, 32'd3);
        seen = 0;
        for (int c = 0; c < 35; c++) begin
            @(posedge clk); #1;
            if (io1.out_valid || io0.out_valid) seen = 1;
        end
        chk("mid_rst_noout", {31'd0, seen}, 32'd0);
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 0);

        // randomized back-to-back operations against the model
        for (int i = 0; i < 150; i++) begin
            ra = rnd_fp();
            rb = rnd_fp();
            if (i % 10 == 3) begin
                ra[30:23] = 8'($urandom_range(245, 254));
                rb[30:23] = 8'($urandom_range(1, 10));
            end else if (i % 10 == 7) begin
                ra[30:23] = 8'($urandom_range(1, 10));
                rb[30:23] = 8'($urandom_range(120, 140));
            end
            e = ref_div(ra, rb);
            run_op(ra, rb, e[31:0], e[35:32], (fcls(ra) != 1) || (fcls(rb) != 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
